// File: rtl/mmio_responder_pkg.sv
// Shared types and address map for the CPU data-memory responder.
// Everything here is imported by mmio_responder and its byte_fifo.
package mmio_responder_pkg;

    typedef logic [31:0] word_t;
    typedef logic [11:0] ram_address_t;

    // Byte addresses of the memory-mapped registers; RAM occupies [0, RAM_LIMIT).
    localparam ram_address_t RAM_LIMIT           = 12'h400;
    localparam ram_address_t MMIO_CONSOLE_DATA   = 12'h400;
    localparam ram_address_t MMIO_CONSOLE_STATUS = 12'h404;
    localparam ram_address_t MMIO_CYCLE          = 12'h408;

    // Low half of the CONSOLE_STATUS read word.
    typedef struct packed {
        logic [7:0] count;
        logic [4:0] reserved;
        logic       overflow;
        logic       empty;
        logic       full;
    } console_status_t;

    // True when addr falls in the same 32-bit word as reg_addr.
    function automatic logic is_reg(ram_address_t addr, ram_address_t reg_addr);
        return addr[11:2] == reg_addr[11:2];
    endfunction

endpackage

// File: rtl/mmio_responder_byte_fifo.sv
// Byte FIFO with an extra wrap bit on each pointer so that full and empty
// are distinguishable and the fill count falls out of a subtraction.
// A push is judged against full as it stands before any same-cycle pop.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Pointer update; both pointers wrap naturally through the extra bit.
    // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write for accepted pushes.
    // NOTE: storage is not reset; head is forced to 0 while empty, so stale entries never leak out.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_responder.sv
// Data-memory responder: scratch RAM, console byte FIFO and cycle counter
// behind one zero-latency read / posedge-write bus.
// Build option: define MMIO_TIMER_EN to include the CYCLE counter at 0x408;
// without it 0x408 reads 0 and writes to it raise bus_error.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] ram_address,
    input  logic        ram_write_enable,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_error
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
`ifdef MMIO_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    word_t               ram_mem [RAM_WORDS];
    logic [RAM_AW-1:0]   ram_index;
    logic                sel_ram;
    logic                sel_con_data;
    logic                sel_con_status;
    logic                sel_cycle;
    logic                aligned;
    logic                mapped;
    logic                write_ok;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_CW-1:0]  fifo_count;
    logic                overflow;
    console_status_t     status;

    // Address decode; higher RAM index bits alias onto the implemented depth.
    assign ram_index      = ram_address[RAM_AW+1:2];
    assign sel_ram        = (ram_address < RAM_LIMIT);
    assign sel_con_data   = is_reg(ram_address, MMIO_CONSOLE_DATA);
    assign sel_con_status = is_reg(ram_address, MMIO_CONSOLE_STATUS);
    assign sel_cycle      = is_reg(ram_address, MMIO_CYCLE);
    assign aligned        = (ram_address[1:0] == 2'b00);
    assign mapped         = sel_ram || sel_con_data || sel_con_status || (TIMER_EN && sel_cycle);
    assign bus_error      = ram_write_enable && !(aligned && mapped);
    assign write_ok       = ram_write_enable && !bus_error;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (write_ok && sel_con_data),
        .push_data(ram_write_data[7:0]),
        .full     (fifo_full),
        .pop      (tx_ready),
        .head     (tx_data),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign tx_valid = !fifo_empty;

    assign status = '{
        count:    8'(fifo_count),
        reserved: 5'b0,
        overflow: overflow,
        empty:    fifo_empty,
        full:     fifo_full
    };

    // Sticky overflow: set by a push that finds the FIFO full, cleared by any status write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (write_ok && sel_con_status) begin
            overflow <= 1'b0;
        end else if (write_ok && sel_con_data && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Scratch RAM; cleared on reset so programs see a known image.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] <= '0;
        end else if (write_ok && sel_ram) begin
            ram_mem[ram_index] <= ram_write_data;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] cycle_count;

    // Free-running cycle counter; a bus write loads it in place of the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (write_ok && sel_cycle) begin
            cycle_count <= ram_write_data;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

    // Zero-latency read mux; CONSOLE_DATA and unmapped words read as 0.
    // NOTE: ram_data gets a default first so no path through the mux infers a latch.
    always_comb begin
        ram_data = '0;
        if (sel_ram) begin
            ram_data = ram_mem[ram_index];
        end else if (sel_con_status) begin
            ram_data = {16'b0, status};
        end
`ifdef MMIO_TIMER_EN
        else if (sel_cycle) begin
            ram_data = cycle_count;
        end
`endif
    end

endmodule
